// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared types and constants for the multi-port register file.
//
// Contents:
//   rf_state_t  clear sequencer state (RF_IDLE, RF_CLEAR)
//   DEF_*       default data width, register count and read port count
//   clog2()     constant-evaluable ceiling log2 used to derive address widths
package regfile_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;
    localparam int DEF_NRD  = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq -- clear sweep sequencer for the register file.
//
// Reset lands in RF_CLEAR, so the array is swept to zero after every reset.
// A clr_req pulse in RF_IDLE starts a new sweep; requests during a sweep are
// ignored. The sweep visits every address exactly once, then returns to idle.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   clr_req   in   request a full clear sweep (honoured only in RF_IDLE)
//   clr_busy  out  1 while sweeping (and while held in reset)
//   clr_we    out  write strobe for the sweep write port
//   clr_addr  out  address being cleared this cycle
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int AW   = clog2(DEF_NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST = AW'(NREG - 1);

    rf_state_t     state, state_nxt;
    logic [AW-1:0] clr_cnt, clr_cnt_nxt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RF_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // NOTE: every output of this block is assigned a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            RF_IDLE: begin
                if (clr_req) begin
                    state_nxt   = RF_CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            RF_CLEAR: begin
                // Exit on the last address instead of wrapping the counter.
                if (clr_cnt == LAST) begin
                    state_nxt   = RF_IDLE;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + AW'(1);
                end
            end
            default: begin
                state_nxt   = RF_CLEAR;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    assign clr_busy = (state == RF_CLEAR);
    assign clr_we   = clr_busy;
    assign clr_addr = clr_cnt;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp -- parametrised register file with NRD registered read ports,
// optional hardwired zero register and a reset/requested clear sweep.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : write-first; an accepted write is forwarded to any port
//               reading the same address in the same cycle.
//   undefined : read-first; a same-cycle read returns the old contents.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   clr_req   in   pulse requesting a full clear sweep
//   clr_busy  out  1 while the clear sweep runs (or reset is held)
//   rd_en     in   sample all read addresses this cycle
//   rd_addr   in   NRD*AW packed read addresses, port i at [i*AW +: AW]
//   rd_data   out  NRD*XLEN packed registered data, port i at [i*XLEN +: XLEN]
//   rd_valid  out  rd_data valid (rd_en accepted the previous cycle)
//   wr_en     in   write request
//   wr_addr   in   write address
//   wr_data   in   write data
//   wr_rdy    out  write accepted this cycle (idle and no clr_req)
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN     = DEF_XLEN,
    parameter  int NREG     = DEF_NREG,
    parameter  int NRD      = DEF_NRD,
    parameter  int ZERO_REG = 1,
    localparam int AW       = clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_req,
    output logic                clr_busy,
    input  logic                rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic                rd_valid,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    output logic                wr_rdy
);

    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          wr_zero;
    logic          user_we;
    logic [XLEN-1:0] mem [NREG];

    regfile_clr_seq #(
        .NREG (NREG),
        .AW   (AW)
    ) u_clr_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A write coinciding with clr_req is refused so the sweep never races it.
    assign wr_rdy  = !clr_busy && !clr_req;
    assign wr_zero = (ZERO_REG != 0) && (wr_addr == '0);
    assign user_we = wr_en && wr_rdy && !wr_zero;

    // NOTE: the array has no reset; it is zeroed by the sweep that follows
    // every reset, which keeps it mappable onto plain RAM/flop arrays.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (user_we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en && !clr_busy;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] val;
        logic [XLEN-1:0] q;

        assign addr = rd_addr[i*AW +: AW];

        always_comb begin
            val = mem[addr];
`ifdef REGFILE_BYPASS_EN
            if (user_we && (wr_addr == addr)) begin
                val = wr_data;
            end
`endif
            // Zero register wins over both storage and forwarding.
            if ((ZERO_REG != 0) && (addr == '0)) begin
                val = '0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
            end else if (clr_busy) begin
                q <= '0;
            end else if (rd_en) begin
                q <= val;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- directed self-checking bench for regfile_mp
// (XLEN=32, NREG=32, NRD=2, ZERO_REG=1). Expected same-cycle collision
// data follows REGFILE_BYPASS_EN.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic        clr_req;
    logic        clr_busy;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_rdy;

    int checks   = 0;
    int failures = 0;

    regfile_mp #(
        .XLEN     (32),
        .NREG     (32),
        .NRD      (2),
        .ZERO_REG (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_rdy   (wr_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic rd2(input logic [4:0] a1, input logic [4:0] a0, output logic [63:0] d);
        rd_addr = {a1, a0};
        rd_en   = 1'b1;
        tick();
        d     = rd_data;
        rd_en = 1'b0;
    endtask

    // Count consecutive busy windows, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (clr_busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    logic [63:0] d;
    logic [31:0] coll_exp;
    int          n;
    bit          bad_rdy, bad_v, bad_d;

    initial begin
        rst_n   = 1'b0;
        clr_req = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;

        // ---------------- reset and initial sweep ----------------
        repeat (3) tick();
        check("rst_busy",    64'(clr_busy), 64'd1);
        check("rst_valid",   64'(rd_valid), 64'd0);
        check("rst_data",    rd_data,       64'd0);
        check("rst_wr_rdy",  64'(wr_rdy),   64'd0);
        rst_n = 1'b1;
        n = 0;
        bad_rdy = 1'b0;
        while (clr_busy && n < 100) begin
            n++;
            if (wr_rdy) bad_rdy = 1'b1;
            tick();
        end
        check("init_busy_cycles", 64'(n), 64'd32);
        check("init_wr_rdy_low",  64'(bad_rdy), 64'd0);
        check("idle_wr_rdy",      64'(wr_rdy), 64'd1);
        for (int i = 0; i < 16; i++) begin
            rd2(5'(2*i+1), 5'(2*i), d);
            check($sformatf("init_zero_r%0d", 2*i), d, 64'd0);
        end
        check("init_rd_valid", 64'(rd_valid), 64'd1);

        // ---------------- write then read ----------------
        wr(5'd5, 32'hDEADBEEF);
        rd2(5'd0, 5'd5, d);
        check("wr5_rd_valid", 64'(rd_valid), 64'd1);
        check("wr5_ports",    d, {32'h0, 32'hDEADBEEF});
        tick();
        check("hold_valid", 64'(rd_valid), 64'd0);
        check("hold_data",  rd_data, {32'h0, 32'hDEADBEEF});

        // ---------------- zero register ----------------
        wr_en   = 1'b1;
        wr_addr = 5'd0;
        wr_data = 32'h1234;
        #1;
        check("zero_wr_rdy", 64'(wr_rdy), 64'd1);
        tick();
        wr_en = 1'b0;
        rd2(5'd0, 5'd0, d);
        check("zero_read", d, 64'd0);
        // Write and read reg0 in the same cycle: still zero.
        wr_en   = 1'b1;
        wr_data = 32'hFFFF_FFFF;
        rd2(5'd0, 5'd0, d);
        wr_en = 1'b0;
        check("zero_collide", d, 64'd0);

        // ---------------- same-cycle collision ----------------
        wr(5'd7, 32'h11);
`ifdef REGFILE_BYPASS_EN
        coll_exp = 32'hA5A5A5A5;
`else
        coll_exp = 32'h11;
`endif
        wr_en   = 1'b1;
        wr_addr = 5'd7;
        wr_data = 32'hA5A5A5A5;
        rd2(5'd7, 5'd7, d);
        wr_en = 1'b0;
        check("collide_ports", d, {coll_exp, coll_exp});
        rd2(5'd5, 5'd7, d);
        check("collide_after", d, {32'hDEADBEEF, 32'hA5A5A5A5});

        // ---------------- mid-operation clear ----------------
        wr(5'd1, 32'h0101);
        wr(5'd2, 32'h0202);
        wr(5'd3, 32'h0303);
        wr(5'd4, 32'h0404);
        rd2(5'd4, 5'd3, d);
        check("load_34", d, {32'h0404, 32'h0303});
        clr_req = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_data = 32'h55;
        #1;
        check("clr_req_wr_rdy", 64'(wr_rdy), 64'd0);
        tick();
        clr_req = 1'b0;
        wr_data = 32'h77;
        rd_en   = 1'b1;
        rd_addr = {5'd2, 5'd1};
        n = 0;
        bad_rdy = 1'b0;
        bad_v   = 1'b0;
        bad_d   = 1'b0;
        while (clr_busy && n < 100) begin
            n++;
            if (wr_rdy) bad_rdy = 1'b1;
            if (rd_valid) bad_v = 1'b1;
            if (n >= 2 && rd_data != 64'd0) bad_d = 1'b1;
            clr_req = (n == 10);
            tick();
        end
        clr_req = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        check("clr_busy_cycles", 64'(n), 64'd32);
        check("clr_wr_rdy_low",  64'(bad_rdy), 64'd0);
        check("clr_rd_valid",    64'(bad_v), 64'd0);
        check("clr_rd_data",     64'(bad_d), 64'd0);
        check("clr_end_data",    rd_data, 64'd0);
        rd2(5'd2, 5'd1, d);
        check("clr_r12", d, 64'd0);
        rd2(5'd4, 5'd3, d);
        check("clr_r34", d, 64'd0);
        rd2(5'd7, 5'd5, d);
        check("clr_r57", d, 64'd0);

        // ---------------- async reset while idle ----------------
        wr(5'd9, 32'h99);
        rd2(5'd9, 5'd9, d);
        check("pre_rst_valid", 64'(rd_valid), 64'd1);
        check("pre_rst_data",  d, {32'h99, 32'h99});
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy",  64'(clr_busy), 64'd1);
        check("arst_valid", 64'(rd_valid), 64'd0);
        check("arst_data",  rd_data, 64'd0);
        tick();
        rst_n = 1'b1;
        count_busy(n);
        check("arst_sweep", 64'(n), 64'd32);

        // ---------------- async reset mid-sweep ----------------
        wr(5'd9, 32'h99);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0;
        while (clr_busy && n < 12) begin
            n++;
            tick();
        end
        check("mid_reached_12", 64'(n), 64'd12);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_arst_busy",  64'(clr_busy), 64'd1);
        check("mid_arst_valid", 64'(rd_valid), 64'd0);
        check("mid_arst_data",  rd_data, 64'd0);
        check("mid_arst_rdy",   64'(wr_rdy), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        count_busy(n);
        check("mid_restart_sweep", 64'(n), 64'd32);
        rd2(5'd9, 5'd5, d);
        check("mid_r95", d, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
